// File: rtl/memoria_dados_pkg.sv
// Shared constants and types for the on-chip data RAM arbiter.
package memoria_dados_pkg;

  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 32;
  localparam int BE_W_DEF     = DATA_W_DEF / 8;
  localparam int MAX_HOLD_DEF = 8;

  typedef logic port_id_t;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_t;

endpackage

// File: rtl/memoria_dados_rr_grant.sv
// Two-requester round-robin grant with a bounded hold; reusable for any
// shared single-port slave.
module memoria_dados_rr_grant #(
  parameter int MAX_HOLD = memoria_dados_pkg::MAX_HOLD_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  output logic [1:0] grant
);
  import memoria_dados_pkg::*;

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  port_id_t          owner;
  logic [HOLD_W-1:0] hold_cnt;
  logic              req_owner;
  logic              req_other;
  logic              grant_owner;
  logic              grant_other;
  port_id_t          grant_port;
  arb_state_t        state;

  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] cnt);
    return (cnt == HOLD_MAX) ? HOLD_MAX : cnt + HOLD_W'(1);
  endfunction

  always_comb begin
    req_owner   = owner ? req1 : req0;
    req_other   = owner ? req0 : req1;
    // The waiting port takes over when the owner is done, idle, or has used its quota.
    grant_other = req_other & (~req_owner | (hold_cnt == '0) | (hold_cnt == HOLD_MAX));
    grant_owner = req_owner & ~grant_other;
    grant_port  = grant_other ? ~owner : owner;
    grant       = 2'b00;
    if (grant_owner | grant_other) begin
      grant[grant_port] = 1'b1;
    end
    if (hold_cnt == '0) begin
      state = IDLE;
    end else begin
      state = owner ? OWN1 : OWN0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= 1'b1;
      hold_cnt <= '0;
    end else if (grant_owner) begin
      hold_cnt <= hold_sat_inc(hold_cnt);
    end else if (grant_other) begin
      owner    <= ~owner;
      hold_cnt <= HOLD_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

  always @(posedge clk) begin
    if (reset_n && hold_cnt == HOLD_MAX) begin
      if (state == OWN0 && req1) assert (grant[1]);
      if (state == OWN1 && req0) assert (grant[0]);
    end
  end

endmodule

// File: rtl/memoria_dados_arbiter.sv
// Shares the single-port 4096x32 data RAM between the Nios II data master
// (port 0) and the RANSAC accelerator master (port 1).
module memoria_dados_arbiter #(
  parameter int ADDR_W   = memoria_dados_pkg::ADDR_W_DEF,
  parameter int DATA_W   = memoria_dados_pkg::DATA_W_DEF,
  parameter int MAX_HOLD = memoria_dados_pkg::MAX_HOLD_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  input  logic [DATA_W-1:0]     ram_readdata
);
  import memoria_dados_pkg::*;

  logic       req0;
  logic       req1;
  logic [1:0] grant;
  logic       rd_vld0_p1;
  logic       rd_vld1_p1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  memoria_dados_rr_grant #(
    .MAX_HOLD(MAX_HOLD)
  ) u_rr_grant (
    .clk    (clk),
    .reset_n(reset_n),
    .req0   (req0),
    .req1   (req1),
    .grant  (grant)
  );

  // Stage p0: RAM command mux, port 0 parks on the bus when nobody is granted
  always_comb begin
    ram_address    = m0_address;
    ram_byteenable = m0_byteenable;
    ram_writedata  = m0_writedata;
    ram_write      = grant[0] & m0_write;
    if (grant[1]) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
      ram_write      = m1_write;
    end
  end

  assign ram_chipselect = |grant;
  assign m0_waitrequest = req0 & ~grant[0];
  assign m1_waitrequest = req1 & ~grant[1];

  // Stage p1: read return; a read+write request counts as a write only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld0_p1 <= 1'b0;
      rd_vld1_p1 <= 1'b0;
    end else begin
      rd_vld0_p1 <= grant[0] & m0_read & ~m0_write;
      rd_vld1_p1 <= grant[1] & m1_read & ~m1_write;
    end
  end

  assign m0_readdatavalid = rd_vld0_p1;
  assign m1_readdatavalid = rd_vld1_p1;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

  always @(posedge clk) begin
    if (reset_n) assert (!(rd_vld0_p1 && rd_vld1_p1));
  end

endmodule

// File: tb/tb_memoria_dados_arbiter.sv
// Bench for memoria_dados_arbiter: directed vector table, hold/reset
// sequences and randomized traffic against a reference memory model.
module tb_memoria_dados_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [11:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata = '0;

  int tests = 0;
  int fails = 0;

  memoria_dados_arbiter #(
    .ADDR_W(12), .DATA_W(32), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM: read data appears one cycle after the address edge.
  logic [31:0] ram_mem [4096] = '{5: 32'h5A5A0001, default: 32'h0};
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= ram_mem[ram_address];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string nm, input int idx, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %b, expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic check_word(input string nm, input int idx, input logic [31:0] act,
                            input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive0(input logic [1:0] op, input logic [11:0] a, input logic [3:0] be,
                        input logic [31:0] d);
    m0_read = op[0]; m0_write = op[1]; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic drive1(input logic [1:0] op, input logic [11:0] a, input logic [3:0] be,
                        input logic [31:0] d);
    m1_read = op[0]; m1_write = op[1]; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive0(2'd0, 12'h0, 4'h0, 32'h0);
    drive1(2'd0, 12'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // op: 0 idle, 1 read, 2 write, 3 read+write; flags = {wait0, wait1, rdv0, rdv1, cs, we}
  typedef struct {
    logic [1:0]  op0;
    logic [11:0] a0;
    logic [3:0]  be0;
    logic [31:0] d0;
    logic [1:0]  op1;
    logic [11:0] a1;
    logic [3:0]  be1;
    logic [31:0] d1;
    logic [5:0]  flags;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs [12];

  task automatic run_table();
    vecs[0]  = '{2'd0, 12'h000, 4'h0, 32'h0,        2'd0, 12'h000, 4'h0, 32'h0,        6'b000000, 32'h0};
    vecs[1]  = '{2'd2, 12'h010, 4'hF, 32'h11111111, 2'd2, 12'h020, 4'hF, 32'h22222222, 6'b010011, 32'h0};
    vecs[2]  = '{2'd0, 12'h000, 4'h0, 32'h0,        2'd2, 12'h020, 4'hF, 32'h22222222, 6'b000011, 32'h0};
    vecs[3]  = '{2'd1, 12'h005, 4'hF, 32'h0,        2'd0, 12'h000, 4'h0, 32'h0,        6'b000010, 32'h0};
    vecs[4]  = '{2'd1, 12'h010, 4'hF, 32'h0,        2'd1, 12'h020, 4'hF, 32'h0,        6'b011010, 32'h5A5A0001};
    vecs[5]  = '{2'd0, 12'h000, 4'h0, 32'h0,        2'd1, 12'h020, 4'hF, 32'h0,        6'b001010, 32'h11111111};
    vecs[6]  = '{2'd2, 12'h100, 4'h2, 32'hAABBCCDD, 2'd0, 12'h000, 4'h0, 32'h0,        6'b000111, 32'h22222222};
    vecs[7]  = '{2'd1, 12'h100, 4'hF, 32'h0,        2'd0, 12'h000, 4'h0, 32'h0,        6'b000010, 32'h0};
    vecs[8]  = '{2'd0, 12'h000, 4'h0, 32'h0,        2'd0, 12'h000, 4'h0, 32'h0,        6'b001000, 32'h0000CC00};
    vecs[9]  = '{2'd3, 12'h005, 4'hF, 32'h12345678, 2'd0, 12'h000, 4'h0, 32'h0,        6'b000011, 32'h0};
    vecs[10] = '{2'd1, 12'h005, 4'hF, 32'h0,        2'd0, 12'h000, 4'h0, 32'h0,        6'b000010, 32'h0};
    vecs[11] = '{2'd0, 12'h000, 4'h0, 32'h0,        2'd0, 12'h000, 4'h0, 32'h0,        6'b001000, 32'h12345678};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive0(vecs[i].op0, vecs[i].a0, vecs[i].be0, vecs[i].d0);
      drive1(vecs[i].op1, vecs[i].a1, vecs[i].be1, vecs[i].d1);
      #1;
      check_bit("tbl_wait0", i, m0_waitrequest, vecs[i].flags[5]);
      check_bit("tbl_wait1", i, m1_waitrequest, vecs[i].flags[4]);
      check_bit("tbl_rdv0", i, m0_readdatavalid, vecs[i].flags[3]);
      check_bit("tbl_rdv1", i, m1_readdatavalid, vecs[i].flags[2]);
      check_bit("tbl_cs", i, ram_chipselect, vecs[i].flags[1]);
      check_bit("tbl_we", i, ram_write, vecs[i].flags[0]);
      if (vecs[i].flags[3]) check_word("tbl_rdata0", i, m0_readdata, vecs[i].erd);
      if (vecs[i].flags[2]) check_word("tbl_rdata1", i, m1_readdata, vecs[i].erd);
    end
  endtask

  task automatic run_hold();
    int m1_run = 0;
    int m0_acc = -1;
    int m0_wait = 0;
    logic m1_after = 1'b0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive1(2'd1, 12'(c), 4'hF, 32'h0);
      drive0((c >= 2 && m0_acc < 0) ? 2'd1 : 2'd0, 12'h005, 4'hF, 32'h0);
      #1;
      if (m0_read && m0_waitrequest) m0_wait++;
      if (m0_read && !m0_waitrequest) m0_acc = c;
      if (!m1_waitrequest && m0_acc < 0) m1_run++;
      if (m0_acc >= 0 && c == m0_acc + 1) m1_after = !m1_waitrequest;
    end
    check_word("hold_m1_run", 0, 32'(m1_run), 32'd8);
    check_word("hold_m0_accept_cycle", 0, 32'(m0_acc), 32'd8);
    check_word("hold_m0_wait", 0, 32'(m0_wait), 32'd6);
    check_bit("hold_m1_regains", 0, m1_after, 1'b1);
  endtask

  task automatic run_reset_mid_read();
    do_reset();
    @(negedge clk);
    drive1(2'd1, 12'h005, 4'hF, 32'h0);
    #1;
    check_bit("rst_m1_accept", 0, m1_waitrequest, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    drive1(2'd0, 12'h000, 4'h0, 32'h0);
    #1;
    check_bit("rst_rdv1_dropped", 0, m1_readdatavalid, 1'b0);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_bit("rst_rdv1_dropped", i, m1_readdatavalid, 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    drive0(2'd1, 12'h005, 4'hF, 32'h0);
    drive1(2'd1, 12'h020, 4'hF, 32'h0);
    #1;
    check_bit("rst_tie_wait0", 0, m0_waitrequest, 1'b0);
    check_bit("rst_tie_wait1", 0, m1_waitrequest, 1'b1);
    check_bit("rst_rdv1_after", 0, m1_readdatavalid, 1'b0);
    @(negedge clk);
    drive0(2'd0, 12'h000, 4'h0, 32'h0);
    drive1(2'd0, 12'h000, 4'h0, 32'h0);
    #1;
    check_bit("rst_tie_rdv0", 0, m0_readdatavalid, 1'b1);
  endtask

  // Randomized traffic in a private window of the RAM, checked against ref_mem
  // and against the arbitration rules expressed as run lengths.
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  logic [1:0]  r_op [2];
  logic [3:0]  r_idx [2];
  logic [3:0]  r_be [2];
  logic [31:0] r_wd [2];
  logic        r_hold [2];
  logic        exp_v [2];
  logic [31:0] exp_d [2];
  int          wait_cnt [2];

  task automatic run_random(input int ncyc);
    logic last_win;
    int   run;
    logic req [2];
    logic any;
    logic win;
    logic gnt [2];
    do_reset();
    last_win = 1'b1;
    run = 0;
    for (int p = 0; p < 2; p++) begin
      r_hold[p] = 1'b0; exp_v[p] = 1'b0; exp_d[p] = '0; wait_cnt[p] = 0;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!r_hold[p]) begin
          r_op[p]  = ($urandom_range(99) < 65) ? 2'($urandom_range(3, 1)) : 2'd0;
          r_idx[p] = 4'($urandom_range(15));
          r_be[p]  = 4'($urandom);
          r_wd[p]  = $urandom;
        end
      end
      drive0(r_op[0], 12'h200 + 12'(r_idx[0]), r_be[0], r_wd[0]);
      drive1(r_op[1], 12'h200 + 12'(r_idx[1]), r_be[1], r_wd[1]);
      #1;
      req[0] = (r_op[0] != 2'd0);
      req[1] = (r_op[1] != 2'd0);
      any = req[0] | req[1];
      if (req[0] && req[1]) win = (run == 0 || run >= MAX_HOLD) ? ~last_win : last_win;
      else win = req[1];
      gnt[0] = any && (win == 1'b0);
      gnt[1] = any && (win == 1'b1);

      check_bit("rnd_wait0", c, m0_waitrequest, req[0] & ~gnt[0]);
      check_bit("rnd_wait1", c, m1_waitrequest, req[1] & ~gnt[1]);
      check_bit("rnd_rdv0", c, m0_readdatavalid, exp_v[0]);
      check_bit("rnd_rdv1", c, m1_readdatavalid, exp_v[1]);
      if (exp_v[0]) check_word("rnd_rdata0", c, m0_readdata, exp_d[0]);
      if (exp_v[1]) check_word("rnd_rdata1", c, m1_readdata, exp_d[1]);
      tests++;
      if (m0_readdatavalid && m1_readdatavalid) begin
        fails++;
        $display("FAIL rnd_dual_rdv[%0d]: both readdatavalid high, required at most one", c);
      end

      for (int p = 0; p < 2; p++) begin
        exp_v[p] = 1'b0;
        wait_cnt[p] = (req[p] && !gnt[p]) ? wait_cnt[p] + 1 : 0;
        if (req[p] && !gnt[p]) begin
          tests++;
          if (wait_cnt[p] > MAX_HOLD) begin
            fails++;
            $display("FAIL rnd_starve%0d[%0d]: waited %0d cycles, limit %0d", p, c, wait_cnt[p], MAX_HOLD);
          end
        end
        r_hold[p] = req[p] && !gnt[p];
        if (gnt[p]) begin
          if (r_op[p] == 2'd1) begin
            exp_v[p] = 1'b1;
            exp_d[p] = ref_mem[r_idx[p]];
          end else begin
            for (int b = 0; b < 4; b++)
              if (r_be[p][b]) ref_mem[r_idx[p]][8*b +: 8] = r_wd[p][8*b +: 8];
          end
        end
      end

      if (!any) run = 0;
      else if (win == last_win) run = (run >= MAX_HOLD) ? MAX_HOLD : run + 1;
      else begin
        last_win = win;
        run = 1;
      end
    end
    @(negedge clk);
    drive0(2'd0, 12'h000, 4'h0, 32'h0);
    drive1(2'd0, 12'h000, 4'h0, 32'h0);
  endtask

  initial begin
    run_table();
    run_hold();
    run_reset_mid_read();
    run_random(10000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memoria_dados_arbiter.md
# memoria_dados_arbiter

Two-port arbiter sharing the single-port 4096×32 on-chip data RAM between the Nios II data master (port 0) and the RANSAC accelerator master (port 1). It presents two Avalon-MM pipelined slave interfaces with waitrequest and readdatavalid. It drives the RAM's address, byteenable, chipselect, write and writedata. Bounded round-robin fairness applies: each port keeps the RAM for at most MAX_HOLD consecutive cycles while the other port waits.

## Interface
- ADDR_W, 12, word address width (4096 words)
- DATA_W, 32, data width
- MAX_HOLD, 8, max consecutive grants to one port while the other requests (≥1)
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- m0_address, m1_address  in  ADDR_W  word address per port
- m0_byteenable, m1_byteenable  in  DATA_W/8  byte lanes
- m0_read, m1_read  in  1  read request
- m0_write, m1_write  in  1  write request
- m0_writedata, m1_writedata  in  DATA_W  write data
- m0_waitrequest, m1_waitrequest  out  1  request not accepted this cycle
- m0_readdata, m1_readdata  out  DATA_W  read data
- m0_readdatavalid, m1_readdatavalid  out  1  readdata valid
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  DATA_W/8  to RAM
- ram_chipselect  out  1  to RAM
- ram_write  out  1  to RAM
- ram_writedata  out  DATA_W  to RAM
- ram_readdata  in  DATA_W  from RAM; valid one cycle after the address edge

## Operation
- reqN = mN_read | mN_write. If both read and write are high, the request is treated as a write and produces no readdatavalid.
- State is {owner ∈ {0,1}, hold_cnt ∈ 0..MAX_HOLD}. The states are:
  - IDLE: hold_cnt = 0.
  - OWN0: owner = 0, hold_cnt > 0.
  - OWN1: owner = 1, hold_cnt > 0.
- Grant rule, combinational, evaluated each cycle. "other" is the non-owner port.
  - Grant other if req_other and (~req_owner, or hold_cnt = 0, or hold_cnt = MAX_HOLD).
  - Otherwise grant owner if req_owner.
  - Otherwise no grant.
- State update at each clock edge:
  - Grant to the same owner: hold_cnt increments, saturating at MAX_HOLD.
  - Grant switches port: owner ← granted port, hold_cnt ← 1.
  - No grant: hold_cnt ← 0, owner unchanged (→ IDLE).
- On both requesting from IDLE, the non-owner wins. owner resets to 1, so port 0 wins the first tie.
- RAM mux, combinational:
  - ram_* carry the granted port's address, byteenable and writedata.
  - ram_chipselect = any grant.
  - ram_write = granted port's write.
  - With no grant, ram_chipselect and ram_write are 0. ram_address, ram_byteenable and ram_writedata hold port 0's values.
- mN_waitrequest = reqN & ~grantN. It is 0 when the port is idle.
- Read return:
  - rd_pendN is registered, set to 1 the cycle after a granted read-only access on port N.
  - mN_readdatavalid = rd_pendN.
  - mN_readdata = ram_readdata, passed through combinationally, for both ports.
- At most one readdatavalid is high per cycle.

## Timing
- Reset values: owner = 1, hold_cnt = 0 (IDLE), rd_pend0 = rd_pend1 = 0.
- Therefore readdatavalid = 0, ram_chipselect = 0, ram_write = 0.
- waitrequest follows its request input combinationally, even during reset.
- Write latency: accepted on the cycle with waitrequest = 0; the RAM is written at that edge.
- Read latency: readdatavalid exactly 1 cycle after acceptance.
- Throughput: one access per cycle. Back-to-back reads from the same port pipeline fully.
- Port switch costs no bubble: the new owner is served in the cycle the old one is preempted.
- Read after write to the same address, any port, in a later cycle returns the new data.
- Reset asserted mid-read: pending readdatavalid is dropped immediately and not re-issued.
- Starvation bound: a requesting port waits at most MAX_HOLD cycles.

## Structure
- Package memoria_dados_pkg holds:
  - ADDR_W, DATA_W, BE_W = DATA_W/8, MAX_HOLD default.
  - typedef port_id_t (1-bit owner).
  - typedef arb_state_t {IDLE, OWN0, OWN1}, used for debug/assertions.
- Sub-module memoria_dados_rr_grant:
  - Inputs: req0, req1. Output: grant[1:0].
  - Contains the owner/hold_cnt registers, so it can be reused for other shared slaves.
- The top level holds the mux, waitrequest and read-return logic.

## Test plan
- Reset, then m0 reads address 0x005 (RAM preset 0x5A5A0001):
  - waitrequest 0 at acceptance.
  - m0_readdatavalid = 1 one cycle later with readdata = 0x5A5A0001.
  - m1_readdatavalid stays 0.
- Both ports write from IDLE (m0: 0x010 ← 0x11111111, m1: 0x020 ← 0x22222222):
  - m0 is granted first, m1 waitrequest = 1 for 1 cycle.
  - Subsequent reads return both values.
- m1 issues 20 continuous reads while m0 requests from cycle 2, MAX_HOLD = 8:
  - m1 is granted for exactly 8 cycles.
  - m0 is granted next; the wait never exceeds 8 cycles.
- m0 writes byteenable 4'b0010 data 0xAABBCCDD to 0x100 (preset 0):
  - A read of 0x100 returns 0x0000CC00.
- m1 read accepted, then reset_n pulsed low on the next edge:
  - m1_readdatavalid never asserts.
  - After release, state is IDLE and the first tie goes to m0.
- Random mixed traffic, 10k cycles, against a reference memory model:
  - Every read matches the model.
  - Readdatavalid is never simultaneous on both ports.
  - Wait never exceeds MAX_HOLD.
